// File: rtl/frame_store.sv
// frame_store: AXI4 write master that stores one AXI-Stream frame into memory via INCR bursts.
// Optional macro FRAME_STORE_FIFO_EN adds a BURST_LEN-deep word FIFO so every burst streams back-to-back.
module frame_store #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 24,
  parameter int unsigned BURST_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned CNT_MAX = (FRAME_WORDS > BURST_LEN) ? FRAME_WORDS : BURST_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SIZE    = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_W-1:0]      remaining;
  logic [CNT_W-1:0]      word_idx;
  logic [CNT_W-1:0]      beats;
  logic [7:0]            beat;
  logic [7:0]            len;
  logic                  aw_ok;
  logic                  w_src_valid;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  in_frame;
  logic                  aw_hs, w_hs, b_hs, s_hs, last_beat;
  logic                  unused_bid;

  assign unused_bid = ^m_axi_bid;

  // Current burst size: full bursts until the frame tail.
  assign beats     = (remaining < CNT_W'(BURST_LEN)) ? remaining : CNT_W'(BURST_LEN);
  assign len       = 8'(beats - CNT_W'(1));
  assign in_frame  = (state == S_AW) || (state == S_W) || (state == S_B);
  assign last_beat = (beat == len);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_hs  = m_axi_bready && m_axi_bvalid;
  assign s_hs  = s_axis_tvalid && s_axis_tready;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = len;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = w_src_data;
  assign m_axi_wlast   = (state == S_W) && last_beat;

`ifdef FRAME_STORE_FIFO_EN
  localparam int unsigned PTR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned LVL_W = $clog2(BURST_LEN + 1);

  logic [DATA_WIDTH-1:0] fifo_mem [BURST_LEN];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  fifo_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BURST_LEN - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full   = (level == LVL_W'(BURST_LEN));
  assign aw_ok       = (CNT_W'(level) >= beats);
  assign w_src_valid = (level != '0);
  assign w_src_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (s_hs) fifo_mem[wr_ptr] <= s_axis_tdata;
  end

  // Level tracks push/pop; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (s_hs) wr_ptr <= ptr_inc(wr_ptr);
      if (w_hs) rd_ptr <= ptr_inc(rd_ptr);
      case ({s_hs, w_hs})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end
`else
  assign aw_ok       = 1'b1;
  assign w_src_valid = s_axis_tvalid;
  assign w_src_data  = s_axis_tdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_AW;
      S_AW:    if (aw_hs) state_nxt = S_W;
      S_W:     if (w_hs && last_beat) state_nxt = S_B;
      S_B:     if (b_hs) state_nxt = (remaining == beats) ? S_DONE : S_AW;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Channel handshake decode from the current state.
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    s_axis_tready = 1'b0;
    if (state == S_AW) m_axi_awvalid = aw_ok;
    if (state == S_W)  m_axi_wvalid  = w_src_valid;
    if (state == S_B)  m_axi_bready  = 1'b1;
`ifdef FRAME_STORE_FIFO_EN
    s_axis_tready = in_frame && !fifo_full && (word_idx != CNT_W'(FRAME_WORDS));
`else
    if (state == S_W)  s_axis_tready = m_axi_wready;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      word_idx  <= '0;
      beat      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == S_IDLE) && start) begin
        busy      <= 1'b1;
        err       <= 1'b0;
        addr      <= ADDR_WIDTH'(BASE_ADDR);
        remaining <= CNT_W'(FRAME_WORDS);
        word_idx  <= '0;
      end
      if (aw_hs)     beat <= '0;
      else if (w_hs) beat <= beat + 8'd1;
      // tlast must coincide exactly with the final word of the frame.
      if (s_hs) begin
        word_idx <= word_idx + CNT_W'(1);
        if (s_axis_tlast != (word_idx == CNT_W'(FRAME_WORDS - 1))) err <= 1'b1;
      end
      if (b_hs) begin
        if (m_axi_bresp != 2'b00) err <= 1'b1;
        addr      <= addr + (ADDR_WIDTH'(beats) << SIZE);
        remaining <= remaining - beats;
        if (remaining == beats) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
